// File: rtl/lsu_mem_initiator.sv
// Load/store unit driving the data memory port: one request per handshake,
// doubleword-aligned reads with split handling, byte extraction and extension.
module lsu_mem_initiator #(
   parameter int                ADDR_W    = 64,
   parameter int                DATA_W    = 64,
   parameter logic [ADDR_W-1:0] RAM_BASE  = 64'h8000_0000,
   parameter int                RAM_BYTES = 32768
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_store,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [4:0]        req_rd,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [4:0]        rsp_rd,
   output logic              rsp_err,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        wdt_op,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, LD0, LD1, LD2, ST, RESP} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [1:0]        size;
      logic              uns;
      logic              split;
   } ctx_t;

   // One extra bit so the end-of-access sum cannot wrap past 2^ADDR_W.
   localparam logic [ADDR_W:0] RAM_LO = {1'b0, RAM_BASE};
   localparam logic [ADDR_W:0] RAM_HI = RAM_LO + (ADDR_W+1)'(RAM_BYTES);

   state_t            state, state_d;
   ctx_t              ctx, ctx_d;
   logic [DATA_W-1:0] beat0, beat0_d;

   logic              rsp_valid_d, rsp_err_d, mem_ren_d, mem_wen_d;
   logic [DATA_W-1:0] rsp_rdata_d, mem_wdata_d;
   logic [4:0]        rsp_rd_d;
   logic [ADDR_W-1:0] mem_raddr_d, mem_waddr_d;
   logic [3:0]        wdt_op_d;

   logic [3:0]        n_bytes;
   logic [2:0]        lo_mask;
   logic              in_range, misalign, req_err, req_split;
   logic [ADDR_W-1:0] ctx_aligned;

   assign n_bytes   = 4'b0001 << req_size;
   assign lo_mask   = 3'(n_bytes - 4'd1);
   assign in_range  = ({1'b0, req_addr} >= RAM_LO) &&
                      ({1'b0, req_addr} + {{(ADDR_W-3){1'b0}}, n_bytes} <= RAM_HI);
   assign misalign  = (req_addr[2:0] & lo_mask) != 3'd0;
   assign req_err   = !in_range || (req_is_store && misalign);
   assign req_split = !req_is_store && (({1'b0, req_addr[2:0]} + n_bytes) > 4'd8);

   assign ctx_aligned = {ctx.addr[ADDR_W-1:3], 3'b000};

   // Held low through reset so nothing is accepted before the FSM is known.
   assign req_ready = rst_n && (state == IDLE);

   function automatic logic [DATA_W-1:0] extract(input logic [2*DATA_W-1:0] pair,
                                                 input logic [2:0] off,
                                                 input logic [1:0] size,
                                                 input logic uns);
      logic [2*DATA_W-1:0] shifted;
      logic [DATA_W-1:0]   v;
      shifted = pair >> {off, 3'b000};
      v       = shifted[DATA_W-1:0];
      case (size)
         2'd0:    extract = uns ? DATA_W'(v[7:0])  : {{(DATA_W-8){v[7]}},   v[7:0]};
         2'd1:    extract = uns ? DATA_W'(v[15:0]) : {{(DATA_W-16){v[15]}}, v[15:0]};
         2'd2:    extract = uns ? DATA_W'(v[31:0]) : {{(DATA_W-32){v[31]}}, v[31:0]};
         default: extract = v;
      endcase
   endfunction

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d     = state;
      ctx_d       = ctx;
      beat0_d     = beat0;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata;
      rsp_rd_d    = rsp_rd;
      rsp_err_d   = rsp_err;
      mem_ren_d   = 1'b0;
      mem_raddr_d = mem_raddr;
      mem_wen_d   = 1'b0;
      mem_waddr_d = mem_waddr;
      mem_wdata_d = mem_wdata;
      wdt_op_d    = 4'b1000;

      unique case (state)
         IDLE: begin
            if (req_valid) begin
               ctx_d       = '{addr: req_addr, size: req_size, uns: req_unsigned, split: req_split};
               rsp_rd_d    = req_rd;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
               if (req_err) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else if (req_is_store) begin
                  state_d     = ST;
                  mem_wen_d   = 1'b1;
                  mem_waddr_d = req_addr;
                  mem_wdata_d = req_wdata;
                  wdt_op_d    = 4'b0001 << req_size;
               end else begin
                  state_d     = LD0;
                  mem_ren_d   = 1'b1;
                  mem_raddr_d = {req_addr[ADDR_W-1:3], 3'b000};
               end
            end
         end
         LD0: begin
            state_d     = LD1;
            mem_ren_d   = 1'b1;
            mem_raddr_d = ctx.split ? ctx_aligned + ADDR_W'(8) : ctx_aligned;
         end
         LD1: begin
            beat0_d = mem_rdata;
            if (ctx.split) begin
               state_d = LD2;
            end else begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = extract({{DATA_W{1'b0}}, mem_rdata}, ctx.addr[2:0], ctx.size, ctx.uns);
            end
         end
         LD2: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = extract({mem_rdata, beat0}, ctx.addr[2:0], ctx.size, ctx.uns);
         end
         ST: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
            else           rsp_valid_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state     <= IDLE;
         ctx       <= '0;
         beat0     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_rd    <= '0;
         rsp_err   <= 1'b0;
         mem_ren   <= 1'b0;
         mem_raddr <= '0;
         mem_wen   <= 1'b0;
         mem_waddr <= '0;
         mem_wdata <= '0;
         wdt_op    <= 4'b1000;
      end else begin
         state     <= state_d;
         ctx       <= ctx_d;
         beat0     <= beat0_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
         rsp_rd    <= rsp_rd_d;
         rsp_err   <= rsp_err_d;
         mem_ren   <= mem_ren_d;
         mem_raddr <= mem_raddr_d;
         mem_wen   <= mem_wen_d;
         mem_waddr <= mem_waddr_d;
         mem_wdata <= mem_wdata_d;
         wdt_op    <= wdt_op_d;
      end
   end

endmodule
